// File: rtl/segment_write_scheduler_if.sv
// Request and write-port bundle for the segment write scheduler.
// master = requesters plus register file side; slave = scheduler.
interface segment_write_scheduler_if;
    logic        a_valid;
    logic [2:0]  a_sel;
    logic [15:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [2:0]  b_sel;
    logic [15:0] b_data;
    logic        b_ready;
    logic [2:0]  write_select;
    logic [15:0] write_data;
    logic        write_enable;

    modport master (
        output a_valid, a_sel, a_data,
        output b_valid, b_sel, b_data,
        input  a_ready, b_ready,
        input  write_select, write_data, write_enable
    );

    modport slave (
        input  a_valid, a_sel, a_data,
        input  b_valid, b_sel, b_data,
        output a_ready, b_ready,
        output write_select, write_data, write_enable
    );
endinterface

// File: rtl/segment_write_scheduler.sv
// Round-robin arbitrated, FIFO-buffered segment register write port.
// Optional CS_WRITE_FLUSH_EN adds a cs_flush pulse after a CS commit.
module segment_write_scheduler #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        reset,
    segment_write_scheduler_if.slave    bus,
    input  logic                        hold,
    input  logic                        squash,
    output logic [5:0]                  seg_pending,
    output logic                        bad_sel,
    output logic                        fifo_full
`ifdef CS_WRITE_FLUSH_EN
    ,
    output logic                        cs_flush
`endif
);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [PTR_W:0]   cnt_t;

    ptr_t        rd_q, rd_d, wr_q, wr_d;
    cnt_t        cnt_q, cnt_d;
    logic        rr_q, rr_d;
    logic        bad_q, bad_d;
    logic [2:0]  sel_q  [DEPTH];
    logic [2:0]  sel_d  [DEPTH];
    logic [15:0] data_q [DEPTH];
    logic [15:0] data_d [DEPTH];

    logic        empty, full, contest;
    logic        a_gnt, b_gnt, a_acc, b_acc, acc;
    logic        sel_ok, push, pop;
    logic [2:0]  in_sel;
    logic [15:0] in_data;
    logic [5:0]  pend;

    always_comb begin
        empty   = (cnt_q == '0);
        full    = (cnt_q == cnt_t'(DEPTH));
        contest = bus.a_valid & bus.b_valid;
        // rr_q = 0 favours A, 1 favours B
        a_gnt   = ~contest | ~rr_q;
        b_gnt   = ~contest | rr_q;
        bus.a_ready = a_gnt & ~full & ~squash;
        bus.b_ready = b_gnt & ~full & ~squash;
        a_acc   = bus.a_valid & bus.a_ready;
        b_acc   = bus.b_valid & bus.b_ready;
        acc     = a_acc | b_acc;
        in_sel  = a_acc ? bus.a_sel  : bus.b_sel;
        in_data = a_acc ? bus.a_data : bus.b_data;
        sel_ok  = (in_sel < 3'd6);
        push    = acc & sel_ok;
        pop     = ~empty & ~hold & ~squash;

        bus.write_enable = pop;
        bus.write_select = empty ? 3'd0  : sel_q[rd_q];
        bus.write_data   = empty ? 16'd0 : data_q[rd_q];

        sel_d  = sel_q;
        data_d = data_q;
        rd_d   = rd_q;
        wr_d   = wr_q;
        cnt_d  = cnt_q;
        bad_d  = 1'b0;
        rr_d   = (contest & acc) ? ~rr_q : rr_q;

        if (squash) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) begin
                sel_d[wr_q]  = in_sel;
                data_d[wr_q] = in_data;
                wr_d         = wr_q + ptr_t'(1);
            end
            if (pop) rd_d = rd_q + ptr_t'(1);
            cnt_d = cnt_q + cnt_t'(push) - cnt_t'(pop);
            bad_d = acc & ~sel_ok;
        end
    end

    // An entry is live if its distance from the head is below the count
    always_comb begin
        pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ({1'b0, ptr_t'(i) - rd_q} < cnt_q)
                pend = pend | (6'd1 << sel_q[i]);
        end
    end

    assign seg_pending = pend;
    assign bad_sel     = bad_q;
    assign fifo_full   = full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            rr_q  <= 1'b0;
            bad_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                sel_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
            rr_q   <= rr_d;
            bad_q  <= bad_d;
            sel_q  <= sel_d;
            data_q <= data_d;
        end
    end

`ifdef CS_WRITE_FLUSH_EN
    logic cs_flush_q, cs_flush_d;

    assign cs_flush_d = pop & (bus.write_select == 3'd1);
    assign cs_flush   = cs_flush_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cs_flush_q <= 1'b0;
        else        cs_flush_q <= cs_flush_d;
    end
`endif

endmodule

// File: tb/tb_segment_write_scheduler.sv
// Bench for segment_write_scheduler: vector table plus corner sequences,
// with a queue scoreboard checking every committed write.
module tb_segment_write_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       hold;
    logic       squash;
    logic [5:0] seg_pending;
    logic       bad_sel;
    logic       fifo_full;
`ifdef CS_WRITE_FLUSH_EN
    logic       cs_flush;
`endif

    segment_write_scheduler_if bus();

    segment_write_scheduler #(.DEPTH(4), .PTR_W(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .hold        (hold),
        .squash      (squash),
        .seg_pending (seg_pending),
        .bad_sel     (bad_sel),
        .fifo_full   (fifo_full)
`ifdef CS_WRITE_FLUSH_EN
        ,
        .cs_flush    (cs_flush)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  s;
        logic [15:0] d;
    } wr_t;

    typedef struct {
        logic        av;
        logic [2:0]  as;
        logic [15:0] ad;
        logic        bv;
        logic [2:0]  bs;
        logic [15:0] bd;
        logic        h;
        logic        sq;
        logic        e_ar;
        logic        e_br;
        logic        e_we;
        logic        e_full;
        logic [5:0]  e_pend;
        logic        e_bad;
    } vec_t;

    wr_t  exp_q[$];
    vec_t tbl[14];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Drive at the falling edge, settle, then run the scoreboard.
    task automatic drive(input logic av, input logic [2:0] as,
                         input logic [15:0] ad, input logic bv,
                         input logic [2:0] bs, input logic [15:0] bd,
                         input logic h, input logic sq);
        wr_t e;
        @(negedge clk);
        bus.a_valid = av; bus.a_sel = as; bus.a_data = ad;
        bus.b_valid = bv; bus.b_sel = bs; bus.b_data = bd;
        hold = h; squash = sq;
        #1;
        if (bus.write_enable) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'(bus.write_select), 32'hdead);
            end else begin
                e = exp_q.pop_front();
                chk("write_select", 32'(bus.write_select), 32'(e.s));
                chk("write_data", 32'(bus.write_data), 32'(e.d));
            end
        end
        if (av && bus.a_ready && as < 3'd6) exp_q.push_back('{s: as, d: ad});
        if (bv && bus.b_ready && bs < 3'd6) exp_q.push_back('{s: bs, d: bd});
        if (sq) exp_q.delete();
    endtask

    task automatic idle(input logic h);
        drive(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, h, 1'b0);
    endtask

    function automatic vec_t mk(
        input logic av, input logic [2:0] as, input logic [15:0] ad,
        input logic bv, input logic [2:0] bs, input logic [15:0] bd,
        input logic h, input logic ar, input logic br, input logic we,
        input logic fu, input logic [5:0] pe);
        vec_t v;
        v.av = av; v.as = as; v.ad = ad;
        v.bv = bv; v.bs = bs; v.bd = bd;
        v.h = h; v.sq = 1'b0;
        v.e_ar = ar; v.e_br = br; v.e_we = we;
        v.e_full = fu; v.e_pend = pe; v.e_bad = 1'b0;
        return v;
    endfunction

    initial begin
        // single write latency, then contested fill under hold and drain
        tbl[0]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 1, 0, 0, 6'h00);
        tbl[1]  = mk(1, 3, 16'h1234, 0, 0, 16'h0000, 0, 1, 1, 0, 0, 6'h00);
        tbl[2]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 1, 1, 0, 6'h08);
        tbl[3]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 1, 0, 0, 6'h00);
        tbl[4]  = mk(1, 0, 16'h00a0, 1, 1, 16'h00b0, 1, 1, 0, 0, 0, 6'h00);
        tbl[5]  = mk(1, 0, 16'h00a1, 1, 1, 16'h00b0, 1, 0, 1, 0, 0, 6'h01);
        tbl[6]  = mk(1, 0, 16'h00a1, 1, 2, 16'h00b2, 1, 1, 0, 0, 0, 6'h03);
        tbl[7]  = mk(1, 0, 16'h00a3, 1, 2, 16'h00b2, 1, 0, 1, 0, 0, 6'h03);
        tbl[8]  = mk(1, 0, 16'h00a3, 1, 2, 16'h00b4, 1, 0, 0, 0, 1, 6'h07);
        tbl[9]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 1, 1, 6'h07);
        tbl[10] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 1, 1, 0, 6'h07);
        tbl[11] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 1, 1, 0, 6'h05);
        tbl[12] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 1, 1, 0, 6'h04);
        tbl[13] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 1, 0, 0, 6'h00);

        reset = 1'b0;
        hold = 1'b0; squash = 1'b0;
        bus.a_valid = 1'b0; bus.a_sel = '0; bus.a_data = '0;
        bus.b_valid = 1'b0; bus.b_sel = '0; bus.b_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_a_ready", 32'(bus.a_ready), 32'd1);
        chk("rst_b_ready", 32'(bus.b_ready), 32'd1);
        chk("rst_we", 32'(bus.write_enable), 32'd0);
        chk("rst_wsel", 32'(bus.write_select), 32'd0);
        chk("rst_wdata", 32'(bus.write_data), 32'd0);
        chk("rst_pend", 32'(seg_pending), 32'd0);
        chk("rst_full", 32'(fifo_full), 32'd0);
        chk("rst_bad", 32'(bad_sel), 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].av, tbl[i].as, tbl[i].ad,
                  tbl[i].bv, tbl[i].bs, tbl[i].bd, tbl[i].h, tbl[i].sq);
            chk($sformatf("t%0d_a_ready", i), 32'(bus.a_ready), 32'(tbl[i].e_ar));
            chk($sformatf("t%0d_b_ready", i), 32'(bus.b_ready), 32'(tbl[i].e_br));
            chk($sformatf("t%0d_we", i), 32'(bus.write_enable), 32'(tbl[i].e_we));
            chk($sformatf("t%0d_full", i), 32'(fifo_full), 32'(tbl[i].e_full));
            chk($sformatf("t%0d_pend", i), 32'(seg_pending), 32'(tbl[i].e_pend));
            chk($sformatf("t%0d_bad", i), 32'(bad_sel), 32'(tbl[i].e_bad));
        end

        // same-segment ordering under hold
        drive(1, 0, 16'h0010, 0, 0, 0, 1, 0);
        chk("es1_ready", 32'(bus.a_ready), 32'd1);
        drive(1, 0, 16'h0020, 0, 0, 0, 1, 0);
        chk("es2_ready", 32'(bus.a_ready), 32'd1);
        chk("es2_pend", 32'(seg_pending), 32'h01);
        idle(1);
        chk("es_hold_we", 32'(bus.write_enable), 32'd0);
        chk("es_hold_pend", 32'(seg_pending), 32'h01);
        idle(0);
        chk("es_first_we", 32'(bus.write_enable), 32'd1);
        chk("es_first_pend", 32'(seg_pending), 32'h01);
        idle(0);
        chk("es_second_we", 32'(bus.write_enable), 32'd1);
        chk("es_second_pend", 32'(seg_pending), 32'h01);
        idle(0);
        chk("es_done_pend", 32'(seg_pending), 32'h00);

        // invalid select from B
        drive(0, 0, 0, 1, 7, 16'hffff, 0, 0);
        chk("bad_b_ready", 32'(bus.b_ready), 32'd1);
        chk("bad_we0", 32'(bus.write_enable), 32'd0);
        idle(0);
        chk("bad_pulse", 32'(bad_sel), 32'd1);
        chk("bad_we1", 32'(bus.write_enable), 32'd0);
        chk("bad_pend", 32'(seg_pending), 32'h00);
        idle(0);
        chk("bad_clear", 32'(bad_sel), 32'd0);

        // squash with three buffered entries
        drive(1, 0, 16'h0001, 0, 0, 0, 1, 0);
        drive(1, 1, 16'h0002, 0, 0, 0, 1, 0);
        drive(1, 3, 16'h0003, 0, 0, 0, 1, 0);
        drive(1, 4, 16'h0004, 0, 0, 0, 1, 1);
        chk("sq_we", 32'(bus.write_enable), 32'd0);
        chk("sq_a_ready", 32'(bus.a_ready), 32'd0);
        chk("sq_pend_before", 32'(seg_pending), 32'h0b);
        idle(0);
        chk("sq_we_after", 32'(bus.write_enable), 32'd0);
        chk("sq_pend_after", 32'(seg_pending), 32'h00);
        chk("sq_full_after", 32'(fifo_full), 32'd0);
        drive(1, 4, 16'h0044, 0, 0, 0, 0, 0);
        chk("post_sq_ready", 32'(bus.a_ready), 32'd1);
        idle(0);
        chk("post_sq_we", 32'(bus.write_enable), 32'd1);
        chk("post_sq_pend", 32'(seg_pending), 32'h10);

        // full FIFO with concurrent pop, pointers wrap
        for (int k = 0; k < 4; k++)
            drive(1, 5, 16'h0050 + 16'(k), 0, 0, 0, 1, 0);
        idle(1);
        chk("wrap_full", 32'(fifo_full), 32'd1);
        chk("wrap_pend", 32'(seg_pending), 32'h20);
        drive(1, 2, 16'h0077, 0, 0, 0, 0, 0);
        chk("wrap_ready_full", 32'(bus.a_ready), 32'd0);
        chk("wrap_we_full", 32'(bus.write_enable), 32'd1);
        drive(1, 2, 16'h0077, 0, 0, 0, 0, 0);
        chk("wrap_ready_next", 32'(bus.a_ready), 32'd1);
        chk("wrap_full_next", 32'(fifo_full), 32'd0);
        for (int k = 0; k < 3; k++) begin
            idle(0);
            chk($sformatf("wrap_drain%0d_we", k), 32'(bus.write_enable), 32'd1);
        end
        idle(0);
        chk("wrap_empty_we", 32'(bus.write_enable), 32'd0);
        chk("wrap_empty_pend", 32'(seg_pending), 32'h00);

`ifdef CS_WRITE_FLUSH_EN
        drive(1, 1, 16'h00c5, 0, 0, 0, 0, 0);
        idle(0);
        chk("cs_we", 32'(bus.write_enable), 32'd1);
        chk("cs_flush_pre", 32'(cs_flush), 32'd0);
        idle(0);
        chk("cs_flush_pulse", 32'(cs_flush), 32'd1);
        idle(0);
        chk("cs_flush_end", 32'(cs_flush), 32'd0);
`endif

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/segment_write_scheduler.md
Name: segment_write_scheduler

Overview:
Shares the single write port of the segment register file between two requesters: A (execute writeback: MOV Sreg, POP Sreg) and B (microcode sequencer: far JMP/CALL/RET, LDS/LES). Accepted requests are arbitrated round-robin and buffered in an in-order FIFO. Entries drain onto the file's write_select/write_data/write_enable. A per-segment pending scoreboard lets decode stall readers of a segment with an in-flight write.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2.
PTR_W, 2, pointer width; equals log2(DEPTH).

Ports:
clk  input  1  clock; all state changes on rising edge.
reset  input  1  asynchronous, active-low reset.
a_valid  input  1  requester A has a write.
a_sel  input  3  A segment select: 0 ES, 1 CS, 2 SS, 3 DS, 4 FS, 5 GS.
a_data  input  16  A selector value.
a_ready  output  1  A accepted this cycle when a_valid & a_ready.
b_valid  input  1  requester B has a write.
b_sel  input  3  B segment select.
b_data  input  16  B selector value.
b_ready  output  1  B accepted this cycle when b_valid & b_ready.
hold  input  1  write port blocked; no drain this cycle.
squash  input  1  pipeline flush; discard all buffered writes.
write_select  output  3  to file write_select.
write_data  output  16  to file write_data.
write_enable  output  1  to file write_enable.
seg_pending  output  6  bit i set if any valid FIFO entry targets segment i.
bad_sel  output  1  one-cycle pulse; accepted request had select 6 or 7.
fifo_full  output  1  FIFO holds DEPTH entries.

Behaviour:
- Reset (reset=0, async): FIFO empty, rd/wr pointers 0, RR pointer = A, bad_sel 0, write_enable 0. Outputs from reset: a_ready/b_ready 1, seg_pending 0, fifo_full 0, write_select 0, write_data 0.
- Acceptance:
  - At most one request per cycle.
  - Only A or only B valid: that one is granted.
  - Both valid: grant to the RR pointer's requester; RR pointer then flips to the other requester. The RR pointer changes only on a contested grant.
  - Ready is combinational: x_ready = x_granted & ~fifo_full & ~squash. The loser sees ready 0.
  - FIFO full: no push, even if a pop happens the same cycle.
- Invalid select (6/7): the request is accepted (ready 1) but not pushed. bad_sel pulses the next cycle.
- Drain:
  - write_enable = ~empty & ~hold & ~squash, combinational.
  - write_select and write_data = head entry; they are 0 when empty.
  - The head is popped on the edge where write_enable=1.
  - Latency: a request accepted at edge N into an empty FIFO, with hold=0, asserts write_enable during cycle N to N+1. Data is in the file after edge N+1.
- Order: strict FIFO order. Two writes to the same segment commit in acceptance order.
- Simultaneous push and pop on a non-full FIFO: count unchanged, both pointers advance, wrap modulo DEPTH.
- seg_pending: OR of decoded selects over valid entries, combinational from FIFO state. It includes the head until the edge it commits.
- squash:
  - While high: no accept, no write.
  - On the edge: empty the FIFO (rd=wr=0). RR pointer is kept; bad_sel is cleared.
  - squash has priority over hold.
- hold: freezes the FIFO head. Pushes continue until full.
- An async reset mid-drain drops all entries. No partial write occurs, because write_enable is gated low immediately.

Optional Feature:
CS_WRITE_FLUSH_EN
- Defined: adds output cs_flush (1 bit, reset 0). It is a registered pulse, high for the one cycle after a write_enable with write_select=1 (CS committed), so fetch can refetch with the new code segment.
- Not defined: port absent; no extra logic.

Test Plan:
- Reset, A writes sel 3 data 16'h1234, hold=0 -> a_ready=1; next cycle write_enable=1, select=3, data=1234; seg_pending[3]=1 until that edge, then 0.
- A and B valid every cycle, 4 cycles, hold=1 -> grants A,B,A,B; fifo_full=1; both ready=0 on cycle 5. Release hold -> writes drain in grant order, one per cycle.
- hold=1, push ES=0x10 then ES=0x20 -> seg_pending=6'b000001; after release, ES writes 0x10 then 0x20; seg_pending clears only after the second write.
- B sel=7 data 0xFFFF -> b_ready=1, no write_enable, bad_sel high for one cycle, seg_pending unchanged.
- Three entries buffered under hold, assert squash for one cycle -> no write_enable, seg_pending=0, fifo_full=0. A subsequent A request commits normally.
- Full FIFO, hold=0, A valid -> a_ready=0 that cycle (pop only). Next cycle a_ready=1 and the pointer wraps correctly. With CS_WRITE_FLUSH_EN, a CS commit yields a one-cycle cs_flush in the following cycle.
